// File: rtl/zuart_pkg.sv
// Shared types and helpers for the zuart transmit arbiter slice.
package zuart_pkg;

    localparam int ZUART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arbState_t;

    // Width of a requester index; never below one bit.
    function automatic int zuartIdw(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : 1;
    endfunction

endpackage

// File: rtl/zuart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for zuart_tx_arbiter.
interface zuart_tx_arbiter_if
    import zuart_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]              iReq;
    logic [ZUART_BYTE_W*N_REQ-1:0] iReqData;
    logic [N_REQ-1:0]              oAck;
    logic [ZUART_BYTE_W-1:0]       oTxData;
    logic                          oTxEn;
    logic                          iTxDone;

    // master is the arbiter; slave is the requesters plus transmitter
    modport master (input iReq, iReqData, iTxDone, output oAck, oTxData, oTxEn);
    modport slave  (output iReq, iReqData, iTxDone, input oAck, oTxData, oTxEn);
endinterface

// File: rtl/zuart_rr_pick.sv
// Combinational round-robin search: first set request after index `last`, wrapping.
module zuart_rr_pick
    import zuart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = zuartIdw(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path can infer a latch.
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/zuart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ sources.
// Optional watchdog on a stuck transmitter: define ZUART_ARB_TIMEOUT_EN.
module zuart_tx_arbiter
    import zuart_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDW            = zuartIdw(N_REQ)
) (
    input  logic               iClk,
    input  logic               iRst_N,
    zuart_tx_arbiter_if.master bus,
    output logic               oBusy,
    output logic [IDW-1:0]     oGrantId,
    output logic               oErr
);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : gBadParam
        $error("zuart_tx_arbiter: N_REQ must be 2..16 and TIMEOUT_CYCLES 2..65536");
    end

    arbState_t               state, stateNext;
    logic [IDW-1:0]          last, lastNext, grantNext, pickIdx;
    logic                    pickValid;
    logic [N_REQ-1:0]        ackNext;
    logic [ZUART_BYTE_W-1:0] txDataNext;
    logic                    txEnNext;
    logic [ZUART_BYTE_W-1:0] reqBytes [N_REQ];

`ifdef ZUART_ARB_TIMEOUT_EN
    logic [15:0] cnt, cntNext;
    logic        errNext;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : gBytes
        assign reqBytes[g] = bus.iReqData[ZUART_BYTE_W*g +: ZUART_BYTE_W];
    end

    zuart_rr_pick #(.N_REQ(N_REQ)) uPick (
        .req   (bus.iReq),
        .last  (last),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    always_comb begin
        stateNext  = state;
        lastNext   = last;
        grantNext  = oGrantId;
        ackNext    = '0;
        txDataNext = bus.oTxData;
        txEnNext   = bus.oTxEn;
`ifdef ZUART_ARB_TIMEOUT_EN
        cntNext    = cnt;
        errNext    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pickValid) begin
                    stateNext        = SEND;
                    lastNext         = pickIdx;
                    grantNext        = pickIdx;
                    ackNext[pickIdx] = 1'b1;
                    txDataNext       = reqBytes[pickIdx];
                    txEnNext         = 1'b1;
`ifdef ZUART_ARB_TIMEOUT_EN
                    cntNext          = '0;
`endif
                end
            end
            SEND: begin
                // A done pulse beats a simultaneous watchdog expiry.
                if (bus.iTxDone) begin
                    txEnNext  = 1'b0;
                    stateNext = GAP;
                end
`ifdef ZUART_ARB_TIMEOUT_EN
                else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    txEnNext  = 1'b0;
                    errNext   = 1'b1;
                    stateNext = GAP;
                end else begin
                    cntNext = cnt + 16'd1;
                end
`endif
            end
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state       <= IDLE;
            last        <= IDW'(N_REQ - 1);
            oGrantId    <= '0;
            bus.oAck    <= '0;
            bus.oTxData <= '0;
            bus.oTxEn   <= 1'b0;
`ifdef ZUART_ARB_TIMEOUT_EN
            cnt         <= '0;
            oErr        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state       <= stateNext;
            last        <= lastNext;
            oGrantId    <= grantNext;
            bus.oAck    <= ackNext;
            bus.oTxData <= txDataNext;
            bus.oTxEn   <= txEnNext;
`ifdef ZUART_ARB_TIMEOUT_EN
            cnt         <= cntNext;
            oErr        <= errNext;
`endif
        end
    end

`ifndef ZUART_ARB_TIMEOUT_EN
    assign oErr = 1'b0;
`endif

    assign oBusy = (state != IDLE);

endmodule
